kmeans_iter_sched: RTL and testbench
====================================

KMEANS_ITER_SCHED -- requirements
Module: kmeans_iter_sched

Interface
REQ-001 SHALL have parameter T, default 16; number of cluster slots (mean file depth).
REQ-002 SHALL have parameter AW, default 16; pixel address/count width.
REQ-003 SHALL have parameter DRAIN, default 4; engine pipeline latency in cycles after last accepted pixel.
REQ-004 SHALL have parameter MAX_ITER, default 64; iteration cap (only with the macro in REQ-033).
REQ-005 SHALL have ports, in order:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  begin a clustering run.
- abort  in  1  cancel the current run.
- num_pixels  in  AW  pixel count N.
- k  in  $clog2(T)+1  active cluster count.
- pix_addr  out  AW  image memory read address.
- pix_valid  out  1  address valid to engines.
- pix_ready  in  1  engines accept the address.
- acc_clear  out  1  clear engine accumulators/counters.
- div_req  out  1  shared divider request.
- div_idx  out  $clog2(T)  cluster being divided.
- div_ack  in  1  divider done with div_idx.
- mean_we  out  1  commit new means to the mean file.
- all_stable  in  1  mean file reports no mean changed.
- iter_cnt  out  8  completed iterations.
- busy  out  1  run in progress.
- done  out  1  one-cycle end-of-run pulse.
- converged  out  1  last run ended on all_stable.

Function
REQ-006 SHALL implement states IDLE, CLEAR, STREAM, DRAIN, DIVIDE, UPDATE, CHECK, DONE.
REQ-007 IDLE: start=1 with num_pixels!=0 and k!=0 SHALL latch N and k, clear iter_cnt and converged, and go to CLEAR; otherwise start is ignored.
REQ-008 k>T SHALL be latched as T.
REQ-009 start while busy=1 SHALL be ignored; num_pixels and k changes after latch SHALL have no effect.
REQ-010 CLEAR: acc_clear=1 for exactly one cycle, pix_addr:=0; next state STREAM.
REQ-011 STREAM: pix_valid=1 with pix_addr stable until pix_valid&pix_ready.
REQ-012 Each handshake SHALL advance pix_addr by 1 on the next cycle.
REQ-013 The handshake at pix_addr=N-1 SHALL move to DRAIN with pix_valid=0 the next cycle; pix_addr SHALL never reach N.
REQ-014 DRAIN SHALL last exactly DRAIN cycles, then go to DIVIDE with div_idx=0.
REQ-015 DIVIDE: div_req=1 with div_idx stable until div_req&div_ack.
REQ-016 On div_req&div_ack in DIVIDE, div_idx SHALL increment by 1 the next cycle; when div_idx=k-1, the next state SHALL be UPDATE.
REQ-017 div_ack without div_req SHALL be ignored.
REQ-018 UPDATE: mean_we=1 for exactly one cycle; next state CHECK.
REQ-019 CHECK: all_stable=1 SHALL set converged=1 and go to DONE.
REQ-020 CHECK: all_stable=0 SHALL increment iter_cnt (saturating at 255) and go to CLEAR.
REQ-021 all_stable SHALL be sampled only in CHECK.
REQ-022 DONE: done=1 for one cycle, then IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 abort=1 in any non-IDLE state SHALL go to IDLE next cycle and deassert pix_valid, div_req, mean_we, acc_clear and busy; done SHALL NOT pulse; iter_cnt and converged hold.
REQ-025 If abort and a pending handshake (pix_ready or div_ack) coincide, abort wins and the handshake is dropped.
REQ-026 If start and abort coincide in IDLE, start wins.
REQ-027 pix_valid, div_req, mean_we and acc_clear SHALL be registered outputs and mutually exclusive.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE.
REQ-029 reset=0 SHALL asynchronously clear pix_addr, div_idx, iter_cnt, the drain counter and every output.
REQ-030 Reset asserted mid-run SHALL abandon the run without a done pulse.
REQ-031 Release SHALL take effect on the first rising clk edge after reset=1.

Configuration
REQ-032 The macro KMEANS_ITER_LIMIT_EN SHALL select whether an iteration cap exists.
REQ-033 With KMEANS_ITER_LIMIT_EN defined: in CHECK with all_stable=0 and iter_cnt+1=MAX_ITER, go to DONE with converged=0.
REQ-034 Without KMEANS_ITER_LIMIT_EN: iterate until all_stable; MAX_ITER is unused.

Structure
REQ-035 Package kmeans_pkg SHALL hold the state enum and the default T and AW constants.
REQ-036 The pixel address counter and its last-pixel compare SHALL be sub-module kmeans_addr_gen.

Verification
REQ-037 N=4, k=2, pix_ready=1, div_ack=1 one cycle after req, all_stable=1 -> addresses 0..3, div_idx 0,1, one mean_we, done pulse, converged=1, iter_cnt=0.
REQ-038 pix_ready toggling 1,0,1,0 -> each address held until accepted; no skipped or repeated address.
REQ-039 all_stable=0 for 2 CHECKs then 1 -> three acc_clear pulses, iter_cnt=2, converged=1.
REQ-040 Macro defined, MAX_ITER=3, all_stable=0 always -> done after third CHECK, converged=0, iter_cnt=2.
REQ-041 abort during DIVIDE at div_idx=1 -> IDLE next cycle, div_req=0, no done.
REQ-042 reset=0 mid-STREAM -> all outputs 0 without a clock edge; start with num_pixels=0 -> stays IDLE.

Source files
------------

// File: rtl/kmeans_pkg.sv
// rtl/kmeans_pkg.sv - shared state encoding and default sizes for the k-means iteration scheduler
package kmeans_pkg;

    localparam int T_DEFAULT  = 16;
    localparam int AW_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DIVIDE,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/kmeans_addr_gen.sv
// rtl/kmeans_addr_gen.sv - pixel read address counter with last-pixel detect
module kmeans_addr_gen
    import kmeans_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    input  logic [AW-1:0] n,
    output logic [AW-1:0] addr,
    output logic          last
);

    // The final address holds rather than wrapping so the counter never shows N.
    assign last = (addr == n - AW'(1));

    // Address restarts at zero for each pass and steps once per accepted pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (clear) begin
            addr <= '0;
        end else if (advance && !last) begin
            addr <= addr + AW'(1);
        end
    end

endmodule

// File: rtl/kmeans_iter_sched.sv
// rtl/kmeans_iter_sched.sv - k-means iteration scheduler; KMEANS_ITER_LIMIT_EN enables the MAX_ITER cap
module kmeans_iter_sched
    import kmeans_pkg::*;
#(
    parameter int T        = T_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int DRAIN    = 4,
    parameter int MAX_ITER = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [AW-1:0]        num_pixels,
    input  logic [$clog2(T):0]   k,
    output logic [AW-1:0]        pix_addr,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 acc_clear,
    output logic                 div_req,
    output logic [$clog2(T)-1:0] div_idx,
    input  logic                 div_ack,
    output logic                 mean_we,
    input  logic                 all_stable,
    output logic [7:0]           iter_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 converged
);

    localparam int IW = $clog2(T);
    localparam int KW = IW + 1;
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

`ifdef KMEANS_ITER_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    sched_state_t  state;
    sched_state_t  next_state;

    logic [AW-1:0] n_lat;
    logic [KW-1:0] k_lat;
    logic [DW-1:0] drain_cnt;

    logic          launch;
    logic          pix_hs;
    logic          div_hs;
    logic          addr_last;
    logic          div_last;
    logic          drain_last;
    logic          cap_hit;

    assign launch     = start && (num_pixels != '0) && (k != '0);
    assign pix_hs     = pix_valid && pix_ready;
    assign div_hs     = div_req && div_ack;
    assign div_last   = ({1'b0, div_idx} == k_lat - KW'(1));
    assign drain_last = (drain_cnt == DW'(DRAIN - 1));
    // With the cap compiled out this folds to zero and MAX_ITER has no effect.
    assign cap_hit    = LIMIT_EN && ((32'(iter_cnt) + 32'd1) == 32'(MAX_ITER));

    kmeans_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (next_state == S_CLEAR),
        .advance (pix_hs && !abort),
        .n       (n_lat),
        .addr    (pix_addr),
        .last    (addr_last)
    );

    // Next-state selection; abort overrides every busy state, start wins in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (launch) next_state = S_CLEAR;
            S_CLEAR:  next_state = S_STREAM;
            S_STREAM: if (pix_hs && addr_last) next_state = S_DRAIN;
            S_DRAIN:  if (drain_last) next_state = S_DIVIDE;
            S_DIVIDE: if (div_hs && div_last) next_state = S_UPDATE;
            S_UPDATE: next_state = S_CHECK;
            S_CHECK:  next_state = (all_stable || cap_hit) ? S_DONE : S_CLEAR;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            next_state = S_IDLE;
        end
    end

    // State register with outputs decoded from the next state so they leave flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pix_valid <= 1'b0;
            acc_clear <= 1'b0;
            div_req   <= 1'b0;
            mean_we   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            pix_valid <= (next_state == S_STREAM);
            acc_clear <= (next_state == S_CLEAR);
            div_req   <= (next_state == S_DIVIDE);
            mean_we   <= (next_state == S_UPDATE);
            done      <= (next_state == S_DONE);
            busy      <= (next_state != S_IDLE);
        end
    end

    // Run parameters are captured once at launch and ignored afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_lat <= '0;
            k_lat <= '0;
        end else if ((state == S_IDLE) && launch) begin
            n_lat <= num_pixels;
            k_lat <= (k > KW'(T)) ? KW'(T) : k;
        end
    end

    // Iteration count and convergence flag; abort leaves both untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_cnt  <= 8'd0;
            converged <= 1'b0;
        end else if ((state == S_IDLE) && launch) begin
            iter_cnt  <= 8'd0;
            converged <= 1'b0;
        end else if ((state == S_CHECK) && !abort) begin
            if (all_stable) begin
                converged <= 1'b1;
            end else if (!cap_hit && (iter_cnt != 8'hFF)) begin
                iter_cnt <= iter_cnt + 8'd1;
            end
        end
    end

    // Drain timer counts the engine pipeline flush after the last pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
        end else if ((state == S_DRAIN) && !drain_last) begin
            drain_cnt <= drain_cnt + DW'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

    // Divider cluster index starts at zero per pass and steps on each accepted divide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_idx <= '0;
        end else if ((state != S_DIVIDE) && (next_state == S_DIVIDE)) begin
            div_idx <= '0;
        end else if ((state == S_DIVIDE) && div_hs && !div_last && !abort) begin
            div_idx <= div_idx + IW'(1);
        end
    end

endmodule

// File: tb/tb_kmeans_iter_sched.sv
// tb/tb_kmeans_iter_sched.sv - self-checking bench for kmeans_iter_sched
module tb_kmeans_iter_sched;

    localparam int T        = 16;
    localparam int AW       = 16;
    localparam int DRAIN    = 4;
    localparam int MAX_ITER = 3;
    localparam int KW       = 5;
    localparam int IW       = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] num_pixels = '0;
    logic [KW-1:0] k = '0;
    logic [AW-1:0] pix_addr;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          acc_clear;
    logic          div_req;
    logic [IW-1:0] div_idx;
    logic          div_ack = 1'b0;
    logic          mean_we;
    logic          all_stable = 1'b0;
    logic [7:0]    iter_cnt;
    logic          busy;
    logic          done;
    logic          converged;

    int n_cmp = 0;
    int n_bad = 0;

    kmeans_iter_sched #(
        .T        (T),
        .AW       (AW),
        .DRAIN    (DRAIN),
        .MAX_ITER (MAX_ITER)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_pixels (num_pixels),
        .k          (k),
        .pix_addr   (pix_addr),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .acc_clear  (acc_clear),
        .div_req    (div_req),
        .div_idx    (div_idx),
        .div_ack    (div_ack),
        .mean_we    (mean_we),
        .all_stable (all_stable),
        .iter_cnt   (iter_cnt),
        .busy       (busy),
        .done       (done),
        .converged  (converged)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] out_vec();
        return {pix_addr, pix_valid, acc_clear, div_req, div_idx, mean_we,
                iter_cnt, busy, done, converged};
    endfunction

    // One complete run; expected results come from the iteration rules, not the RTL.
    task automatic run_job(input string name, input int n, input int kk, input int s,
                           input int rmode, input int amode);
        int keff, iters, exp_cnt, budget, cyc, last_hs, age;
        int clears, wes, dones, bad_excl, bad_hold, bad_range, bad_drain, bad_ord;
        bit exp_conv, fin, pend, dpend, armed, chk_next, tog;
        int acc_q[$];
        int div_q[$];
        logic [AW-1:0] held;
        logic [IW-1:0] dheld;
        keff = (kk > T) ? T : kk;
        iters = s + 1;
        exp_conv = 1'b1;
        exp_cnt = (s > 255) ? 255 : s;
`ifdef KMEANS_ITER_LIMIT_EN
        if (s >= MAX_ITER) begin
            iters = MAX_ITER;
            exp_conv = 1'b0;
            exp_cnt = MAX_ITER - 1;
        end
`endif
        cyc = 0; last_hs = 0; age = 0;
        clears = 0; wes = 0; dones = 0;
        bad_excl = 0; bad_hold = 0; bad_range = 0; bad_drain = 0;
        fin = 1'b0; pend = 1'b0; dpend = 1'b0; armed = 1'b0; chk_next = 1'b0; tog = 1'b1;
        held = '0; dheld = '0;
        budget = iters * (4 * n + 4 * keff + DRAIN + 12) + 40;

        num_pixels = AW'(n);
        k = KW'(kk);
        abort = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        num_pixels = AW'($urandom);
        k = KW'($urandom);

        while (!fin && cyc < budget) begin
            if ((32'(pix_valid) + 32'(acc_clear) + 32'(div_req) + 32'(mean_we)) > 1) bad_excl++;
            if (busy && (int'(pix_addr) >= n)) bad_range++;
            if (acc_clear) clears++;
            if (done) begin
                dones++;
                fin = 1'b1;
            end

            case (rmode)
                0:       pix_ready = 1'b1;
                1:       begin pix_ready = tog; tog = ~tog; end
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (pix_valid) begin
                if (pend && (pix_addr !== held)) bad_hold++;
                if (pix_ready) begin
                    acc_q.push_back(int'(pix_addr));
                    pend = 1'b0;
                    if (int'(pix_addr) == n - 1) begin
                        armed = 1'b1;
                        last_hs = cyc;
                    end
                end else begin
                    pend = 1'b1;
                    held = pix_addr;
                end
            end else begin
                pend = 1'b0;
            end

            if (div_req) begin
                if (armed) begin
                    if (cyc - last_hs != DRAIN + 1) bad_drain++;
                    armed = 1'b0;
                end
                if (dpend && (div_idx !== dheld)) bad_hold++;
                case (amode)
                    0:       div_ack = 1'b1;
                    1:       div_ack = (age >= 1);
                    default: div_ack = 1'($urandom_range(0, 1));
                endcase
                if (div_ack) begin
                    div_q.push_back(int'(div_idx));
                    dpend = 1'b0;
                    age = 0;
                end else begin
                    dpend = 1'b1;
                    dheld = div_idx;
                    age++;
                end
            end else begin
                div_ack = (amode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                dpend = 1'b0;
                age = 0;
            end

            all_stable = chk_next ? (wes > s) : 1'($urandom_range(0, 1));
            if (mean_we) wes++;
            chk_next = mean_we;
            start = (busy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;

            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        pix_ready = 1'b0;
        div_ack = 1'b0;

        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL %s timeout: no done after %0d cycles, required done", name, cyc);
        end
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s post_done: busy/done=%b required 00", name, {busy, done});
        end
        n_cmp++;
        if (acc_q.size() != iters * n) begin
            n_bad++;
            $display("FAIL %s addr_count: got %0d required %0d", name, acc_q.size(), iters * n);
        end
        bad_ord = 0;
        foreach (acc_q[i]) if (acc_q[i] != i % n) bad_ord++;
        n_cmp++;
        if (bad_ord != 0) begin
            n_bad++;
            $display("FAIL %s addr_order: %0d out-of-order addresses required 0", name, bad_ord);
        end
        n_cmp++;
        if (div_q.size() != iters * keff) begin
            n_bad++;
            $display("FAIL %s div_count: got %0d required %0d", name, div_q.size(), iters * keff);
        end
        bad_ord = 0;
        foreach (div_q[i]) if (div_q[i] != i % keff) bad_ord++;
        n_cmp++;
        if (bad_ord != 0) begin
            n_bad++;
            $display("FAIL %s div_order: %0d out-of-order indices required 0", name, bad_ord);
        end
        n_cmp++;
        if (clears != iters) begin
            n_bad++;
            $display("FAIL %s acc_clear: got %0d pulses required %0d", name, clears, iters);
        end
        n_cmp++;
        if (wes != iters) begin
            n_bad++;
            $display("FAIL %s mean_we: got %0d pulses required %0d", name, wes, iters);
        end
        n_cmp++;
        if (dones != 1) begin
            n_bad++;
            $display("FAIL %s done: got %0d pulses required 1", name, dones);
        end
        n_cmp++;
        if (converged !== exp_conv) begin
            n_bad++;
            $display("FAIL %s converged: got %b required %b", name, converged, exp_conv);
        end
        n_cmp++;
        if (iter_cnt !== 8'(exp_cnt)) begin
            n_bad++;
            $display("FAIL %s iter_cnt: got %0d required %0d", name, iter_cnt, exp_cnt);
        end
        n_cmp++;
        if (bad_excl + bad_hold + bad_range + bad_drain != 0) begin
            n_bad++;
            $display("FAIL %s protocol: excl=%0d hold=%0d range=%0d drain=%0d required all 0",
                     name, bad_excl, bad_hold, bad_range, bad_drain);
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (out_vec() !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_async: outputs=%h required 0", out_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_vec() !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_release: outputs=%h required 0", out_vec());
        end
    endtask

    task automatic test_basic();
        run_job("basic", 4, 2, 0, 0, 1);
    endtask

    task automatic test_ready_toggle();
        run_job("ready_toggle", 4, 3, 0, 1, 0);
    endtask

    task automatic test_iterate();
        run_job("iterate", 3, 2, 2, 0, 2);
    endtask

    task automatic test_iter_cap();
        run_job("iter_cap", 2, 1, 5, 2, 0);
    endtask

    task automatic test_k_clamp();
        run_job("k_clamp", 2, 31, 0, 0, 0);
        run_job("k_full", 1, 16, 1, 2, 2);
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            run_job("random", int'($urandom_range(1, 8)), int'($urandom_range(1, 20)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_saturate();
        run_job("saturate", 1, 1, 260, 0, 0);
    endtask

    task automatic test_abort_divide();
        bit found;
        int dcount;
        found = 1'b0;
        dcount = 0;
        num_pixels = 16'd2;
        k = 5'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            pix_ready = 1'b1;
            all_stable = 1'b0;
            if (div_req && (div_idx == 4'd1)) begin
                abort = 1'b1;
                found = 1'b1;
            end
            div_ack = div_req;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL abort_reach: div_idx=1 never seen, required it");
        end
        n_cmp++;
        if ({busy, div_req, pix_valid, mean_we, acc_clear, done} !== 6'b0) begin
            n_bad++;
            $display("FAIL abort_outputs: busy,req,valid,we,clr,done=%b required 000000",
                     {busy, div_req, pix_valid, mean_we, acc_clear, done});
        end
        n_cmp++;
        if ({iter_cnt, converged} !== 9'd0) begin
            n_bad++;
            $display("FAIL abort_hold: iter_cnt=%0d converged=%b required 0/0", iter_cnt, converged);
        end
        abort = 1'b0;
        div_ack = 1'b0;
        pix_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) dcount++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dcount != 0) begin
            n_bad++;
            $display("FAIL abort_quiet: %0d cycles with done/busy after abort required 0", dcount);
        end
    endtask

    task automatic test_start_abort_idle();
        num_pixels = 16'd3;
        k = 5'd1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if ({busy, acc_clear} !== 2'b11) begin
            n_bad++;
            $display("FAIL start_abort_idle: busy/acc_clear=%b required 11", {busy, acc_clear});
        end
        @(posedge clk); #1;
        abort = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_clear: busy/done=%b required 00", {busy, done});
        end
    endtask

    task automatic test_reset_mid();
        num_pixels = 16'd5;
        k = 5'd2;
        pix_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (pix_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_stream: pix_valid=%b required 1", pix_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (out_vec() !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_mid: outputs=%h required 0", out_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        num_pixels = 16'd0;
        k = 5'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if ({busy, acc_clear} !== 2'b00) begin
            n_bad++;
            $display("FAIL zero_pixels: busy/acc_clear=%b required 00", {busy, acc_clear});
        end
        num_pixels = 16'd3;
        k = 5'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if ({busy, acc_clear} !== 2'b00) begin
            n_bad++;
            $display("FAIL zero_k: busy/acc_clear=%b required 00", {busy, acc_clear});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_toggle();
        test_iterate();
        test_iter_cap();
        test_k_clamp();
        test_random();
        test_saturate();
        test_abort_divide();
        test_start_abort_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
